read_write_logic: RTL and testbench
===================================

Name: read_write_logic

Overview:
Host-bus read/write front end of the 8259A-style programmable interrupt controller. It captures CPU writes from the 8-bit bidirectional data bus and places the byte on the internal bus. It classifies each write as ICW1-ICW4 or OCW1-OCW3 using an initialization sequencer. It drives read data back onto the host bus during CPU reads.

Parameters:
None.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
data_bus_buffer  inout  8  host data bus; driven only during a valid read, else high-Z
internal_bus  output  8  byte from the last committed write
read_data  input  8  byte from control logic (IRR/ISR/IMR select) to present during reads
chip_select_bar  input  1  active-low chip select
read_bar  input  1  active-low read strobe
write_bar  input  1  active-low write strobe
A0  input  1  address bit 0
ICW_1_flag .. ICW_4_flag  output  1 each  last committed write was ICW1/2/3/4
OCW_1_flag .. OCW_3_flag  output  1 each  last committed write was OCW1/2/3

Behaviour:
- Reset is synchronous and active-high, with one clock. On reset:
  - internal_bus = 0 and all seven flags = 0.
  - Init state = UNINIT; captured data, A0, SNGL, IC4 and write_active_q are all 0.
- Write detection:
  - write_active = !chip_select_bar && !write_bar.
  - Each clk edge: write_active_q <= write_active.
  - While write_active is sampled high, data_q <= data_bus_buffer and a0_q <= A0, so the last sampled values win.
- Commit:
  - commit = write_active_q && !write_active, i.e. the first edge where write_bar or chip_select_bar is sampled high after an active write.
  - At the commit edge: internal_bus <= data_q; all flags clear; at most one flag is set per the decode below.
  - Flags and internal_bus hold until the next commit or reset. Toggling A0 or the bus with no write changes nothing.
- Writes with chip_select_bar high are ignored entirely.
- Decode at commit (d = data_q):
  - a0_q=0 and d[4]=1 → ICW1, accepted in any state. Sets ICW_1_flag, stores SNGL=d[1] and IC4=d[0], and moves to WAIT_ICW2. Restarting mid-sequence is legal.
  - WAIT_ICW2, a0_q=1 → ICW_2_flag. Next state: WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW3, a0_q=1 → ICW_3_flag. Next state: WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4, a0_q=1 → ICW_4_flag. Next state: READY.
  - READY, a0_q=1 → OCW_1_flag.
  - READY, a0_q=0, d[4:3]=00 → OCW_2_flag.
  - READY, a0_q=0, d[4:3]=01 → OCW_3_flag.
  - Any other write: no flag, state unchanged, internal_bus still updated. This covers UNINIT, and a0_q=0 non-ICW1 during WAIT states.
- Read:
  - data_bus_buffer = read_data when !chip_select_bar && !read_bar && write_bar (combinational); otherwise 'z'.
  - Reads never alter state or flags.
  - If read_bar and write_bar are both low, the write wins and the bus stays high-Z.
- Reset during an active write aborts it; no commit follows.

Test Plan:
- Reset, then write 0x10 with A0=0 (SNGL=0, IC4=0) → ICW_1_flag=1 only, internal_bus=0x10. Then A0=1 0x20 → ICW_2_flag. Then A0=1 0x04 → ICW_3_flag. Then A0=1 0xFF → OCW_1_flag (READY).
- Write ICW1 0x13 (SNGL=1, IC4=1), then A0=1 0x08 → ICW_2_flag. Then A0=1 0x01 → ICW_4_flag (ICW3 skipped). Then A0=0 0x20 → OCW_2_flag. Then A0=0 0x0B → OCW_3_flag.
- Vary the bus 0x00→0x08 while write_bar is low, then raise write_bar → internal_bus=0x08 at the first edge wr is sampled high; no flag change before that edge; flags hold after.
- chip_select_bar=1 with a write_bar pulse, A0=1 → no flag or internal_bus change. cs=0, read_bar=0, read_data=0x5A → bus=0x5A. read_bar=1 → bus high-Z.
- From UNINIT, write A0=1 0x33 → internal_bus=0x33, all flags 0, state stays UNINIT.
- Assert reset mid-write → flags=0, internal_bus=0. Releasing write_bar afterwards produces no commit.

Source files
------------

// File: rtl/read_write_logic_if.sv
// ---------------------------------------------------------------------------
// read_write_logic_if
// Host-side bus bundle for the interrupt-controller read/write front end.
//
// Signals:
//   chip_select_bar, read_bar, write_bar  active-low host strobes
//   A0                                    host address bit 0
//   read_data                             byte the control logic offers on reads
//   internal_bus                          byte from the last committed write
//   ICW_1_flag .. ICW_4_flag              last committed write was ICW1..ICW4
//   OCW_1_flag .. OCW_3_flag              last committed write was OCW1..OCW3
//
// The bidirectional data bus is deliberately not part of this bundle: it is
// a resolved tri-state net and stays a plain inout on the module so that
// both the host model and the controller can drive it as ordinary wires.
//
// Modports:
//   master : host / environment side (drives strobes, sees flags)
//   slave  : read_write_logic side
// ---------------------------------------------------------------------------
interface read_write_logic_if;
    logic       chip_select_bar;
    logic       read_bar;
    logic       write_bar;
    logic       A0;
    logic [7:0] read_data;
    logic [7:0] internal_bus;
    logic       ICW_1_flag;
    logic       ICW_2_flag;
    logic       ICW_3_flag;
    logic       ICW_4_flag;
    logic       OCW_1_flag;
    logic       OCW_2_flag;
    logic       OCW_3_flag;

    modport master (
        output chip_select_bar, read_bar, write_bar, A0, read_data,
        input  internal_bus,
        input  ICW_1_flag, ICW_2_flag, ICW_3_flag, ICW_4_flag,
        input  OCW_1_flag, OCW_2_flag, OCW_3_flag
    );

    modport slave (
        input  chip_select_bar, read_bar, write_bar, A0, read_data,
        output internal_bus,
        output ICW_1_flag, ICW_2_flag, ICW_3_flag, ICW_4_flag,
        output OCW_1_flag, OCW_2_flag, OCW_3_flag
    );
endinterface

// File: rtl/read_write_logic.sv
// ---------------------------------------------------------------------------
// read_write_logic
// Host read/write front end of an 8259A-style interrupt controller.
// Captures CPU writes from the bidirectional data bus, commits the byte to
// the internal bus when the write strobe ends, classifies the write as
// ICW1..ICW4 / OCW1..OCW3 through an initialization sequencer, and drives
// read data back to the host during CPU reads.
//
// Ports:
//   clk              system clock, all state on rising edge
//   reset            synchronous, active-high
//   data_bus_buffer  host data bus (inout); driven only during a valid read
//   bus              read_write_logic_if.slave (strobes, A0, read_data,
//                    internal_bus, command flags)
//   o_init_state     debug view of the initialization sequencer state
//   o_bus_drive_en   debug view of the data bus output enable
//
// Handshake: a write is active while chip_select_bar and write_bar are both
// low. The byte and A0 are re-sampled on every edge the write is active, so
// the last sample wins. The write commits on the first edge at which the
// write is no longer active after having been active on the previous edge.
// Reads are purely combinational and never change state; if read and write
// strobes are low together, the write wins and the bus stays released.
// ---------------------------------------------------------------------------
module read_write_logic (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [7:0]         data_bus_buffer,
    read_write_logic_if.slave  bus,
    output logic [2:0]         o_init_state,
    output logic               o_bus_drive_en
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } init_state_t;

    // Bit positions inside the packed flag register.
    localparam int F_ICW1 = 6;
    localparam int F_ICW2 = 5;
    localparam int F_ICW3 = 4;
    localparam int F_ICW4 = 3;
    localparam int F_OCW1 = 2;
    localparam int F_OCW2 = 1;
    localparam int F_OCW3 = 0;

    init_state_t r_state;
    init_state_t w_next_state;

    logic [7:0] r_data_q;
    logic       r_a0_q;
    logic       r_write_active_q;
    logic       r_sngl;
    logic       r_ic4;
    logic [7:0] r_internal_bus;
    logic [6:0] r_flags;

    logic       w_write_active;
    logic       w_commit;
    logic       w_read_en;
    logic       w_next_sngl;
    logic       w_next_ic4;
    logic [6:0] w_flag_set;

    assign w_write_active = !bus.chip_select_bar && !bus.write_bar;
    // Falling edge of the sampled write: the strobe was active last edge
    // and is released now.
    assign w_commit       = r_write_active_q && !w_write_active;
    assign w_read_en      = !bus.chip_select_bar && !bus.read_bar && bus.write_bar;

    assign data_bus_buffer = w_read_en ? bus.read_data : 8'hzz;

    // Capture registers and strobe history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q         <= 8'h00;
            r_a0_q           <= 1'b0;
            r_write_active_q <= 1'b0;
        end else begin
            r_write_active_q <= w_write_active;
            if (w_write_active) begin
                r_data_q <= data_bus_buffer;
                r_a0_q   <= bus.A0;
            end
        end
    end

    // Sequencer state, ICW1 mode bits, committed byte and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= UNINIT;
            r_sngl         <= 1'b0;
            r_ic4          <= 1'b0;
            r_internal_bus <= 8'h00;
            r_flags        <= 7'b0;
        end else begin
            r_state <= w_next_state;
            r_sngl  <= w_next_sngl;
            r_ic4   <= w_next_ic4;
            if (w_commit) begin
                r_internal_bus <= r_data_q;
                r_flags        <= w_flag_set;
            end
        end
    end

    // Write decode. ICW1 is recognised in every state so software can
    // restart initialization at any time; everything else depends on where
    // the sequencer is.
    always_comb begin
        w_next_state = r_state;
        w_next_sngl  = r_sngl;
        w_next_ic4   = r_ic4;
        w_flag_set   = 7'b0;
        if (w_commit) begin
            if (!r_a0_q && r_data_q[4]) begin
                w_flag_set[F_ICW1] = 1'b1;
                w_next_sngl        = r_data_q[1];
                w_next_ic4         = r_data_q[0];
                w_next_state       = WAIT_ICW2;
            end else begin
                case (r_state)
                    WAIT_ICW2: begin
                        if (r_a0_q) begin
                            w_flag_set[F_ICW2] = 1'b1;
                            // Cascade mode needs ICW3; single mode skips it.
                            if (!r_sngl)
                                w_next_state = WAIT_ICW3;
                            else if (r_ic4)
                                w_next_state = WAIT_ICW4;
                            else
                                w_next_state = READY;
                        end
                    end
                    WAIT_ICW3: begin
                        if (r_a0_q) begin
                            w_flag_set[F_ICW3] = 1'b1;
                            w_next_state       = r_ic4 ? WAIT_ICW4 : READY;
                        end
                    end
                    WAIT_ICW4: begin
                        if (r_a0_q) begin
                            w_flag_set[F_ICW4] = 1'b1;
                            w_next_state       = READY;
                        end
                    end
                    READY: begin
                        // d[4] is known to be 0 here (else it was ICW1),
                        // so d[3] alone separates OCW2 from OCW3.
                        if (r_a0_q)
                            w_flag_set[F_OCW1] = 1'b1;
                        else if (!r_data_q[3])
                            w_flag_set[F_OCW2] = 1'b1;
                        else
                            w_flag_set[F_OCW3] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.internal_bus = r_internal_bus;
    assign bus.ICW_1_flag   = r_flags[F_ICW1];
    assign bus.ICW_2_flag   = r_flags[F_ICW2];
    assign bus.ICW_3_flag   = r_flags[F_ICW3];
    assign bus.ICW_4_flag   = r_flags[F_ICW4];
    assign bus.OCW_1_flag   = r_flags[F_OCW1];
    assign bus.OCW_2_flag   = r_flags[F_OCW2];
    assign bus.OCW_3_flag   = r_flags[F_OCW3];

    assign o_init_state   = r_state;
    assign o_bus_drive_en = w_read_en;

endmodule

// File: tb/tb_read_write_logic.sv
// ---------------------------------------------------------------------------
// tb_read_write_logic
// Directed bench for read_write_logic. Inputs change on the falling clock
// edge; outputs are checked on the falling edge, half a cycle after the
// rising edge that updated them.
// Flag vector order: {ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3}.
// ---------------------------------------------------------------------------
module tb_read_write_logic;

    logic       clk;
    logic       reset;
    wire  [7:0] data_bus;
    logic       drv_en;
    logic [7:0] drv_val;
    logic [2:0] init_state;
    logic       bus_drive_en;

    int n_checks;
    int n_fail;

    read_write_logic_if bus_if ();

    assign data_bus = drv_en ? drv_val : 8'hzz;

    read_write_logic dut (
        .clk             (clk),
        .reset           (reset),
        .data_bus_buffer (data_bus),
        .bus             (bus_if.slave),
        .o_init_state    (init_state),
        .o_bus_drive_en  (bus_drive_en)
    );

    wire [6:0] flags = {bus_if.ICW_1_flag, bus_if.ICW_2_flag, bus_if.ICW_3_flag,
                        bus_if.ICW_4_flag, bus_if.OCW_1_flag, bus_if.OCW_2_flag,
                        bus_if.OCW_3_flag};

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] exp_bus,
                           input logic [6:0] exp_flags, input logic [2:0] exp_state);
        chk({tag, " internal_bus"}, bus_if.internal_bus, exp_bus);
        chk({tag, " flags"}, {1'b0, flags}, {1'b0, exp_flags});
        chk({tag, " state"}, {5'b0, init_state}, {5'b0, exp_state});
    endtask

    // Driver: one-cycle write strobe, then release; ends on the falling
    // edge right after the commit edge.
    task automatic do_write(input logic a0, input logic [7:0] d);
        @(negedge clk);
        drv_en                 = 1'b1;
        drv_val                = d;
        bus_if.A0              = a0;
        bus_if.chip_select_bar = 1'b0;
        bus_if.write_bar       = 1'b0;
        @(negedge clk);
        drv_en                 = 1'b0;
        bus_if.write_bar       = 1'b1;
        bus_if.chip_select_bar = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drv_en   = 1'b0;
        drv_val  = 8'h00;
        bus_if.chip_select_bar = 1'b1;
        bus_if.read_bar        = 1'b1;
        bus_if.write_bar       = 1'b1;
        bus_if.A0              = 1'b0;
        bus_if.read_data       = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_out("reset", 8'h00, 7'b0000000, 3'd0);
        chk("reset drive_en", {7'b0, bus_drive_en}, 8'h00);

        // Write before initialization: byte lands, no flag, stays UNINIT.
        do_write(1'b1, 8'h33);
        chk_out("uninit a0=1", 8'h33, 7'b0000000, 3'd0);

        // Cascade mode, no ICW4: ICW1 -> ICW2 -> ICW3 -> READY.
        do_write(1'b0, 8'h10);
        chk_out("icw1 0x10", 8'h10, 7'b1000000, 3'd1);
        do_write(1'b1, 8'h20);
        chk_out("icw2 0x20", 8'h20, 7'b0100000, 3'd2);
        do_write(1'b1, 8'h04);
        chk_out("icw3 0x04", 8'h04, 7'b0010000, 3'd4);
        do_write(1'b1, 8'hFF);
        chk_out("ocw1 0xFF", 8'hFF, 7'b0000100, 3'd4);

        // Single mode with ICW4; includes an unrecognised A0=0 write.
        do_write(1'b0, 8'h13);
        chk_out("icw1 0x13", 8'h13, 7'b1000000, 3'd1);
        do_write(1'b0, 8'h08);
        chk_out("wait a0=0 0x08", 8'h08, 7'b0000000, 3'd1);
        do_write(1'b1, 8'h08);
        chk_out("icw2 0x08", 8'h08, 7'b0100000, 3'd3);
        do_write(1'b1, 8'h01);
        chk_out("icw4 0x01", 8'h01, 7'b0001000, 3'd4);
        do_write(1'b0, 8'h20);
        chk_out("ocw2 0x20", 8'h20, 7'b0000010, 3'd4);
        do_write(1'b0, 8'h0B);
        chk_out("ocw3 0x0B", 8'h0B, 7'b0000001, 3'd4);

        // Bus changes during a long write: last sample wins, commit only
        // after the strobe is released.
        @(negedge clk);
        bus_if.A0              = 1'b1;
        bus_if.chip_select_bar = 1'b0;
        bus_if.write_bar       = 1'b0;
        drv_en                 = 1'b1;
        drv_val                = 8'h00;
        @(negedge clk);
        drv_val = 8'h04;
        @(negedge clk);
        drv_val = 8'h08;
        @(negedge clk);
        chk_out("long write held", 8'h0B, 7'b0000001, 3'd4);
        bus_if.write_bar = 1'b1;
        drv_en           = 1'b0;
        @(negedge clk);
        chk_out("long write commit", 8'h08, 7'b0000100, 3'd4);
        bus_if.chip_select_bar = 1'b1;
        bus_if.A0              = 1'b0;
        drv_en                 = 1'b1;
        drv_val                = 8'hC3;
        repeat (2) @(negedge clk);
        drv_en = 1'b0;
        chk_out("idle hold", 8'h08, 7'b0000100, 3'd4);

        // Write strobe without chip select is ignored.
        @(negedge clk);
        bus_if.A0        = 1'b1;
        drv_en           = 1'b1;
        drv_val          = 8'h77;
        bus_if.write_bar = 1'b0;
        @(negedge clk);
        bus_if.write_bar = 1'b1;
        drv_en           = 1'b0;
        @(negedge clk);
        chk_out("no cs write", 8'h08, 7'b0000100, 3'd4);

        // Read path.
        bus_if.read_data       = 8'h5A;
        bus_if.chip_select_bar = 1'b0;
        bus_if.read_bar        = 1'b0;
        #1;
        chk("read drive_en", {7'b0, bus_drive_en}, 8'h01);
        chk("read data", data_bus, 8'h5A);
        @(negedge clk);
        chk_out("after read", 8'h08, 7'b0000100, 3'd4);
        bus_if.read_bar = 1'b1;
        #1;
        chk("read release drive_en", {7'b0, bus_drive_en}, 8'h00);

        // Read and write together: write wins, bus released, write commits.
        @(negedge clk);
        bus_if.read_bar  = 1'b0;
        bus_if.write_bar = 1'b0;
        drv_en           = 1'b1;
        drv_val          = 8'h44;
        #1;
        chk("rd+wr drive_en", {7'b0, bus_drive_en}, 8'h00);
        @(negedge clk);
        bus_if.read_bar        = 1'b1;
        bus_if.write_bar       = 1'b1;
        bus_if.chip_select_bar = 1'b1;
        drv_en                 = 1'b0;
        @(negedge clk);
        chk_out("rd+wr commit", 8'h44, 7'b0000100, 3'd4);

        // Reset in the middle of a write aborts it.
        @(negedge clk);
        bus_if.A0              = 1'b1;
        bus_if.chip_select_bar = 1'b0;
        bus_if.write_bar       = 1'b0;
        drv_en                 = 1'b1;
        drv_val                = 8'h55;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_out("reset mid-write", 8'h00, 7'b0000000, 3'd0);
        bus_if.write_bar       = 1'b1;
        bus_if.chip_select_bar = 1'b1;
        drv_en                 = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("no commit after reset", 8'h00, 7'b0000000, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
